// File: rtl/sram_chip_model_if.sv
// Pin bundle of the board SRAM, excluding the bidirectional data bus.
// The controller side is master; the chip model is slave.
interface sram_chip_model_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        contention_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N,
    output SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    input  contention_err, wr_count, rd_count
  );

  modport slave (
    input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N,
    input  SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    output contention_err, wr_count, rd_count
  );
endinterface

// File: rtl/sram_chip_model.sv
// Pin-level responder model of a 256Kx16 async SRAM.
// Byte-lane writes, pipelined reads, error flag and access counters.
module sram_chip_model #(
  parameter int ADDR_BITS    = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire  [15:0]        SRAM_DQ,
  sram_chip_model_if.slave   bus
);

  // Stage 0 captures at the sampling edge; the last stage drives,
  // so data appears READ_LATENCY edges after the sampled read.
  localparam int NS    = READ_LATENCY + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] addr;
  logic                 wr_en;
  logic                 rd_en;
  logic                 rd_pins;
  logic                 cont;
  logic                 unused_addr;

  logic        vld_q [NS];
  logic        vld_d [NS];
  logic [15:0] dat_q [NS];
  logic [15:0] dat_d [NS];
  logic        ub_q  [NS];
  logic        ub_d  [NS];
  logic        lb_q  [NS];
  logic        lb_d  [NS];

  logic        err_q;
  logic        err_d;
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;
  logic [15:0] rd_count_q;
  logic [15:0] rd_count_d;

  logic dq_oe_lo;
  logic dq_oe_hi;

  assign addr        = bus.SRAM_ADDR[ADDR_BITS-1:0];
  assign unused_addr = ^bus.SRAM_ADDR;
  assign rd_pins     = ~bus.SRAM_CE_N & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
  assign wr_en       = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
  assign cont        = wr_en & ~bus.SRAM_OE_N;
  assign rd_en       = rd_pins;

  // Array write with per-lane enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!bus.SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
      if (!bus.SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Next state for read pipeline, error flag and saturating counters.
  always_comb begin
    vld_d[0] = rd_en;
    dat_d[0] = mem[addr];
    ub_d[0]  = bus.SRAM_UB_N;
    lb_d[0]  = bus.SRAM_LB_N;
    for (int i = 1; i < NS; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
      ub_d[i]  = ub_q[i-1];
      lb_d[i]  = lb_q[i-1];
    end
    err_d      = err_q | cont;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (wr_en && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
    if (rd_en && rd_count_q != 16'hFFFF)
      rd_count_d = rd_count_q + 16'd1;
  end

  // State registers; reset drops in-flight reads at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= 16'h0000;
        ub_q[i]  <= 1'b1;
        lb_q[i]  <= 1'b1;
      end
      err_q      <= 1'b0;
      wr_count_q <= 16'h0000;
      rd_count_q <= 16'h0000;
    end else begin
      for (int i = 0; i < NS; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
        ub_q[i]  <= ub_d[i];
        lb_q[i]  <= lb_d[i];
      end
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign dq_oe_lo = vld_q[NS-1] & rd_pins & ~lb_q[NS-1];
  assign dq_oe_hi = vld_q[NS-1] & rd_pins & ~ub_q[NS-1];

  assign SRAM_DQ[7:0]  = dq_oe_lo ? dat_q[NS-1][7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = dq_oe_hi ? dat_q[NS-1][15:8] : 8'hzz;

  assign bus.contention_err = err_q;
  assign bus.wr_count       = wr_count_q;
  assign bus.rd_count       = rd_count_q;

endmodule

// File: tb/tb_sram_chip_model.sv
// Bench for sram_chip_model: two instances (latency 1 and 3) on
// shared pins, checked against an array/queue reference model.
module tb_sram_chip_model;

  localparam int AB = 12;
  localparam int DEP = 1 << AB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] paddr = '0;
  logic        pub = 1'b1;
  logic        plb = 1'b1;
  logic        pwe = 1'b1;
  logic        pce = 1'b1;
  logic        poe = 1'b1;
  logic [15:0] wdata = '0;
  logic        wdrv = 1'b0;

  wire [15:0] dq1;
  wire [15:0] dq3;
  assign dq1 = wdrv ? wdata : 16'hzzzz;
  assign dq3 = wdrv ? wdata : 16'hzzzz;

  sram_chip_model_if if1 ();
  sram_chip_model_if if3 ();

  assign if1.SRAM_ADDR = paddr;
  assign if1.SRAM_UB_N = pub;
  assign if1.SRAM_LB_N = plb;
  assign if1.SRAM_WE_N = pwe;
  assign if1.SRAM_CE_N = pce;
  assign if1.SRAM_OE_N = poe;
  assign if3.SRAM_ADDR = paddr;
  assign if3.SRAM_UB_N = pub;
  assign if3.SRAM_LB_N = plb;
  assign if3.SRAM_WE_N = pwe;
  assign if3.SRAM_CE_N = pce;
  assign if3.SRAM_OE_N = poe;

  sram_chip_model #(.ADDR_BITS(AB), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .bus(if1.slave)
  );
  sram_chip_model #(.ADDR_BITS(AB), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .bus(if3.slave)
  );

  typedef struct packed {
    bit          v;
    logic [15:0] d;
    bit          ub;
    bit          lb;
  } ev_t;

  logic [15:0] mem_m [DEP];
  ev_t         hist [$];
  int          m_wr;
  int          m_rd;
  bit          m_err;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 8; i++) hist.push_front('0);
    m_wr  = 0;
    m_rd  = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    ev_t e;
    int  ea;
    ea   = int'(paddr) % DEP;
    e.v  = !pce && pwe && !poe;
    e.d  = mem_m[ea];
    e.ub = pub;
    e.lb = plb;
    hist.push_front(e);
    if (hist.size() > 8) void'(hist.pop_back());
    if (!pce && !pwe) begin
      if (!plb) mem_m[ea][7:0]  = wdata[7:0];
      if (!pub) mem_m[ea][15:8] = wdata[15:8];
      if (m_wr < 65535) m_wr++;
      if (!poe) m_err = 1'b1;
    end
    if (e.v && m_rd < 65535) m_rd++;
  endtask

  function automatic logic [17:0] drv_exp(input int lat);
    bit   g;
    bit   h;
    bit   l;
    ev_t  e;
    e = hist[lat];
    g = e.v && !pce && pwe && !poe;
    h = g && !e.ub;
    l = g && !e.lb;
    return {h, l, h ? e.d[15:8] : 8'h00, l ? e.d[7:0] : 8'h00};
  endfunction

  function automatic logic [17:0] drv1();
    return {u1.dq_oe_hi, u1.dq_oe_lo,
            u1.dq_oe_hi ? dq1[15:8] : 8'h00,
            u1.dq_oe_lo ? dq1[7:0] : 8'h00};
  endfunction

  function automatic logic [17:0] drv3();
    return {u3.dq_oe_hi, u3.dq_oe_lo,
            u3.dq_oe_hi ? dq3[15:8] : 8'h00,
            u3.dq_oe_lo ? dq3[7:0] : 8'h00};
  endfunction

  task automatic check_all();
    logic [32:0] ec;
    ec = {m_err, 16'(m_wr), 16'(m_rd)};
    chk("drive_lat1", 64'(drv1()), 64'(drv_exp(1)));
    chk("drive_lat3", 64'(drv3()), 64'(drv_exp(3)));
    chk("status_lat1",
        64'({if1.contention_err, if1.wr_count, if1.rd_count}), 64'(ec));
    chk("status_lat3",
        64'({if3.contention_err, if3.wr_count, if3.rd_count}), 64'(ec));
  endtask

  task automatic step(input bit ce, input bit we, input bit oe,
                      input bit ub, input bit lb,
                      input logic [17:0] a, input logic [15:0] d);
    pce   = ce;
    pwe   = we;
    poe   = oe;
    pub   = ub;
    plb   = lb;
    paddr = a;
    wdata = d;
    wdrv  = !we;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input bit ub, input bit lb);
    step(1'b0, 1'b0, 1'b1, ub, lb, a, d);
  endtask

  task automatic rd(input logic [17:0] a, input bit ub, input bit lb);
    step(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_dq_z", 64'({u1.dq_oe_hi, u1.dq_oe_lo}), 64'd0);
    rst = 1'b1;
    idle();
    idle();

    // Two halves of a 32-bit word
    wr(18'd2058, 16'h0001, 1'b0, 1'b0);
    wr(18'd2059, 16'h0002, 1'b0, 1'b0);
    rd(18'd2058, 1'b0, 1'b0);
    rd(18'd2059, 1'b0, 1'b0);
    chk("split_lo", 64'(dq1), 64'h0001);
    chk("split_cnt", 64'({if1.wr_count, if1.rd_count}), 64'h0002_0002);
    rd(18'd2059, 1'b0, 1'b0);
    chk("split_hi", 64'(dq1), 64'h0002);
    idle();

    // Byte lanes
    wr(18'd5, 16'hAAAA, 1'b0, 1'b0);
    wr(18'd5, 16'h5555, 1'b1, 1'b0);
    rd(18'd5, 1'b0, 1'b0);
    rd(18'd5, 1'b1, 1'b0);
    chk("lane_full", 64'(dq1), 64'hAA55);
    rd(18'd5, 1'b0, 1'b0);
    chk("lane_lo_only", 64'(drv1()), 64'h1_0055);
    idle();

    // Latency 3 and throughput
    wr(18'd0, 16'h1111, 1'b0, 1'b0);
    wr(18'd1, 16'h2222, 1'b0, 1'b0);
    wr(18'd2, 16'h3333, 1'b0, 1'b0);
    wr(18'd3, 16'h4444, 1'b0, 1'b0);
    rd(18'd0, 1'b0, 1'b0);
    rd(18'd1, 1'b0, 1'b0);
    rd(18'd2, 1'b0, 1'b0);
    chk("lat3_early", 64'({u3.dq_oe_hi, u3.dq_oe_lo}), 64'd0);
    rd(18'd3, 1'b0, 1'b0);
    chk("lat3_w0", 64'(dq3), 64'h1111);
    rd(18'd3, 1'b0, 1'b0);
    chk("lat3_w1", 64'(dq3), 64'h2222);
    rd(18'd3, 1'b0, 1'b0);
    chk("lat3_w2", 64'(dq3), 64'h3333);
    idle();

    // Contention with an address that wraps onto 7
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'(DEP + 7), 16'hBEEF);
    chk("cont_set", 64'(if1.contention_err), 64'd1);
    idle();
    idle();
    rd(18'd7, 1'b0, 1'b0);
    rd(18'd7, 1'b0, 1'b0);
    chk("wrap_data", 64'(dq1), 64'hBEEF);
    chk("cont_held", 64'(if3.contention_err), 64'd1);

    // Reset while reads are in flight
    wr(18'd9, 16'h1234, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0);
    chk("pre_rst_drive", 64'(dq1), 64'h1234);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_release", 64'({u1.dq_oe_hi, u1.dq_oe_lo}), 64'd0);
    #2 rst = 1'b1;
    rd(18'd9, 1'b0, 1'b0);
    chk("no_stale", 64'({u1.dq_oe_hi, u1.dq_oe_lo}), 64'd0);
    rd(18'd9, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0);
    rd(18'd9, 1'b0, 1'b0);
    chk("post_rst_l3", 64'(dq3), 64'h1234);

    // Randomised traffic over a small, fully written window
    for (int i = 0; i < 16; i++)
      wr(18'(i), 16'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [17:0] a;
      bit          c;
      bit          w;
      bit          o;
      a = 18'($urandom_range(0, 15) + $urandom_range(0, 3) * DEP);
      c = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 2) != 0);
      o = ($urandom_range(0, 15) == 0) ? 1'b0 : w ? 1'b0 : 1'b1;
      step(c, w, o, 1'($urandom), 1'($urandom), a, 16'($urandom));
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
